mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, meaning byte-address width of the RAM array (2^17 bytes).
REQ-002 SHALL have parameter TXQ_LOG2, default 3, meaning log2 of the TX queue depth (8 entries).
REQ-003 SHALL provide these ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; all state frozen when low
- mem_a  in  32  byte address from the memory initiator
- mem_wr  in  1  1 = write, 0 = read
- mem_wdata  in  8  write byte
- mem_rdata  out  8  registered read byte
- io_buffer_full  out  1  TX queue near-full back-pressure
- tx_data  out  8  head byte of the TX queue
- tx_valid  out  1  TX queue non-empty
- tx_ready  in  1  consumer accepts tx_data
- rx_data  in  8  incoming input byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  RX holding register empty
- program_finish  out  1  sticky halt flag
- tx_overflow  out  1  sticky dropped-write flag

Function
REQ-004 SHALL treat an access as IO when mem_a[17:16]==2'b11; otherwise it SHALL address RAM byte mem_a[RAM_ADDR_WIDTH-1:0] (upper bits ignored, aliasing).
REQ-005 RAM read SHALL have 1-cycle latency: address presented at cycle N, mem_rdata valid from N+1 until the next enabled edge.
REQ-006 RAM write SHALL commit mem_wdata at the edge where mem_wr=1, rdy_in=1; mem_rdata SHALL then be 0x00 for that cycle.
REQ-007 IO write at 0x30000 SHALL push mem_wdata into the TX queue; if the queue is full the byte SHALL be dropped and tx_overflow set.
REQ-008 IO write at 0x30004 SHALL set program_finish; it remains set until reset.
REQ-009 IO read at 0x30000 SHALL return the RX holding byte (1-cycle latency) and clear it; if empty it SHALL return 0x00.
REQ-010 IO read at 0x30004 SHALL return {6'b0, rx_full, txq_full}; other IO addresses SHALL read 0x00 and ignore writes.
REQ-011 io_buffer_full SHALL be combinational from count: 1 when count >= 2^TXQ_LOG2 - 1 (one slot headroom for an in-flight write).
REQ-012 TX pop SHALL occur when tx_valid && tx_ready; simultaneous push and pop SHALL leave count unchanged; push to a full queue with a simultaneous pop SHALL be accepted.
REQ-013 TX pointers SHALL wrap modulo 2^TXQ_LOG2; count width TXQ_LOG2+1.
REQ-014 RX: rx_ready = !rx_full; byte captured when rx_valid && rx_ready; capture and a read of 0x30000 in the same cycle SHALL return the old byte (0x00 if empty) and keep the new byte.
REQ-015 While rdy_in=0 SHALL perform no RAM write, push, pop, capture or flag change; mem_rdata holds.

Reset
REQ-016 On rst_in at a rising edge: mem_rdata=0x00, queue empty (tx_valid=0, io_buffer_full=0), rx_full=0 (rx_ready=1), program_finish=0, tx_overflow=0; RAM contents SHALL NOT be reset.
REQ-017 Reset SHALL take priority over rdy_in and over any access in the same cycle; an in-flight read SHALL return 0x00.

Configuration
REQ-018 Macro IO_RX_EN: defined -> RX path per REQ-009/014; undefined -> rx_ready tied 0, 0x30000 reads return 0x00, status bit 1 reads 0, RX register not synthesised.

Verification
REQ-019 Write 0xA5 to 0x00001234, then read it -> mem_rdata=0xA5 exactly one cycle after the read address.
REQ-020 Seven writes to 0x30000 with tx_ready=0 -> io_buffer_full=1 after the 7th; 8th accepted; 9th dropped, tx_overflow=1.
REQ-021 Queue 0x11,0x22 then tx_ready=1 -> tx_data 0x11 then 0x22, then tx_valid=0; push during pop -> count unchanged.
REQ-022 rx_valid with 0x5A, then read 0x30000 -> 0x5A, rx_ready=1 after; second read -> 0x00 (IO_RX_EN defined).
REQ-023 Write 0x30004 -> program_finish=1, held with rdy_in toggling, cleared only by rst_in.
REQ-024 Assert rst_in mid-read of a 0xFF RAM byte -> mem_rdata=0x00, all flags clear, RAM byte still 0xFF on re-read.

Source files
------------

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte memory responder: RAM, TX queue, RX holding register, halt flag; optional RX path via IO_RX_EN
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TXQ_LOG2       = 3
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finish,
    output logic        tx_overflow
);
    localparam int RAM_BYTES = 2 ** RAM_ADDR_WIDTH;
    localparam int TXQ_DEPTH = 2 ** TXQ_LOG2;
    localparam logic [TXQ_LOG2:0] CNT_FULL = (TXQ_LOG2 + 1)'(TXQ_DEPTH);
    localparam logic [TXQ_LOG2:0] CNT_NEAR = (TXQ_LOG2 + 1)'(TXQ_DEPTH - 1);
    localparam logic [15:0] OFF_DATA = 16'h0000;
    localparam logic [15:0] OFF_STAT = 16'h0004;

    logic [7:0]          ram [RAM_BYTES];
    logic [7:0]          txq_mem [TXQ_DEPTH];
    logic [TXQ_LOG2-1:0] txq_wr_ptr;
    logic [TXQ_LOG2-1:0] txq_rd_ptr;
    logic [TXQ_LOG2:0]   txq_count;
    logic                txq_full;

    logic       is_io;
    logic       io_data;
    logic       io_stat;
    logic       ram_we;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_accept;
    logic       rx_full;
    logic [7:0] rx_read_byte;
    logic [7:0] rdata_next;
    logic       unused_bits;

    // Address decode: the IO window is selected by bits 17:16, everything else aliases into RAM
    assign is_io   = (mem_a[17:16] == 2'b11);
    assign io_data = is_io && (mem_a[15:0] == OFF_DATA);
    assign io_stat = is_io && (mem_a[15:0] == OFF_STAT);

    // Reset outranks any access, so a write presented during reset never reaches the array
    assign ram_we    = rdy_in && !rst_in && mem_wr && !is_io;
    assign tx_push   = rdy_in && mem_wr && io_data;
    assign tx_pop    = rdy_in && tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands
    assign tx_accept = tx_push && (!txq_full || tx_pop);

    assign txq_full       = (txq_count == CNT_FULL);
    assign tx_valid       = (txq_count != '0);
    assign io_buffer_full = (txq_count >= CNT_NEAR);
    assign tx_data        = txq_mem[txq_rd_ptr];

`ifdef IO_RX_EN
    logic [7:0] rx_byte;
    logic       rx_capture;
    logic       rx_take;

    assign rx_ready     = !rx_full;
    assign rx_capture   = rdy_in && rx_valid && !rx_full;
    assign rx_take      = rdy_in && !mem_wr && io_data;
    assign rx_read_byte = rx_full ? rx_byte : 8'h00;
    assign unused_bits  = ^mem_a[31:18];

    // RX holding register: capture only when empty, so a same-cycle read returns the old (empty) value
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_full <= 1'b0;
        end else if (rx_capture) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end else if (rx_take) begin
            rx_full <= 1'b0;
        end
    end
`else
    assign rx_full      = 1'b0;
    assign rx_ready     = 1'b0;
    assign rx_read_byte = 8'h00;
    assign unused_bits  = ^{mem_a[31:18], rx_data, rx_valid};
`endif

    // Read mux for the byte returned on the next enabled edge; writes return zero
    always_comb begin
        rdata_next = 8'h00;
        if (!mem_wr) begin
            if (!is_io) begin
                rdata_next = ram[mem_a[RAM_ADDR_WIDTH-1:0]];
            end else if (io_data) begin
                rdata_next = rx_read_byte;
            end else if (io_stat) begin
                rdata_next = {6'b000000, rx_full, txq_full};
            end
        end
    end

    // RAM array write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
        end
    end

    // Registered read data, held while the responder is stalled
    always_ff @(posedge clk) begin
        if (rst_in) begin
            mem_rdata <= 8'h00;
        end else if (rdy_in) begin
            mem_rdata <= rdata_next;
        end
    end

    // TX queue storage, written only for accepted pushes
    always_ff @(posedge clk) begin
        if (tx_accept) begin
            txq_mem[txq_wr_ptr] <= mem_wdata;
        end
    end

    // TX queue pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst_in) begin
            txq_wr_ptr  <= '0;
            txq_rd_ptr  <= '0;
            txq_count   <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_accept) begin
                txq_wr_ptr <= txq_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                txq_rd_ptr <= txq_rd_ptr + 1'b1;
            end
            if (tx_accept && !tx_pop) begin
                txq_count <= txq_count + 1'b1;
            end else if (!tx_accept && tx_pop) begin
                txq_count <= txq_count - 1'b1;
            end
            if (tx_push && !tx_accept) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Sticky halt flag raised by a write to the status address
    always_ff @(posedge clk) begin
        if (rst_in) begin
            program_finish <= 1'b0;
        end else if (rdy_in && mem_wr && io_stat) begin
            program_finish <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder against a queue/array reference model
module tb_mem_io_responder;
    localparam int AW    = 17;
    localparam int QL    = 3;
    localparam int DEPTH = 8;
`ifdef IO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif
    localparam logic [31:0] IDLE_A = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_wdata, rx_data;
    logic [7:0]  mem_rdata, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, program_finish, tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  tq[$];
    logic [7:0]  ram_m [int];
    logic [7:0]  exp_rdata = 8'h00;
    bit          rdata_known = 1'b1;
    bit          rx_full_m = 1'b0;
    bit          fin_m = 1'b0;
    bit          ovf_m = 1'b0;
    logic [7:0]  rx_byte_m = 8'h00;
    logic [16:0] pool [16];

    mem_io_responder #(.RAM_ADDR_WIDTH(AW), .TXQ_LOG2(QL)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .program_finish(program_finish),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge
    task automatic cycle(input bit rst, input bit rdy, input bit wr, input logic [31:0] a,
                         input logic [7:0] wd, input bit txr, input bit rxv, input logic [7:0] rxd);
        int          idx;
        bit          io, full, pop, cap, push_ok;
        logic [15:0] off;
        rst_in = rst; rdy_in = rdy; mem_wr = wr; mem_a = a; mem_wdata = wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        if (rst) begin
            exp_rdata = 8'h00; rdata_known = 1'b1;
            tq.delete(); rx_full_m = 1'b0; fin_m = 1'b0; ovf_m = 1'b0;
        end else if (rdy) begin
            io      = (a[17:16] == 2'b11);
            off     = a[15:0];
            idx     = int'(a[AW-1:0]);
            full    = (tq.size() == DEPTH);
            pop     = (tq.size() != 0) && txr;
            cap     = RX_EN && rxv && !rx_full_m;
            push_ok = 1'b0;
            rdata_known = 1'b1;
            if (wr) begin
                exp_rdata = 8'h00;
                if (!io) ram_m[idx] = wd;
                else if (off == 16'h0004) fin_m = 1'b1;
                else if (off == 16'h0000) begin
                    if (full && !pop) ovf_m = 1'b1;
                    else push_ok = 1'b1;
                end
            end else begin
                if (!io) begin
                    if (ram_m.exists(idx)) exp_rdata = ram_m[idx];
                    else rdata_known = 1'b0;
                end else if (off == 16'h0000) begin
                    exp_rdata = rx_full_m ? rx_byte_m : 8'h00;
                    rx_full_m = 1'b0;
                end else if (off == 16'h0004) begin
                    exp_rdata = {6'b000000, rx_full_m, full};
                end else begin
                    exp_rdata = 8'h00;
                end
            end
            if (pop) void'(tq.pop_front());
            if (push_ok) tq.push_back(wd);
            if (cap) begin
                rx_full_m = 1'b1;
                rx_byte_m = rxd;
            end
        end
        @(posedge clk);
        #1;
        if (rdata_known) chk8("mem_rdata", mem_rdata, exp_rdata);
        chk1("tx_valid", tx_valid, tq.size() != 0);
        if (tq.size() != 0) chk8("tx_data", tx_data, tq[0]);
        chk1("io_buffer_full", io_buffer_full, tq.size() >= DEPTH - 1);
        chk1("rx_ready", rx_ready, RX_EN && !rx_full_m);
        chk1("program_finish", program_finish, fin_m);
        chk1("tx_overflow", tx_overflow, ovf_m);
    endtask

    task automatic idle(input bit txr);
        cycle(1'b0, 1'b1, 1'b0, IDLE_A, 8'h00, txr, 1'b0, 8'h00);
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r <= 5) begin
            a       = $urandom;
            a[16:0] = pool[$urandom_range(0, 15)];
            a[17]   = 1'b0;
        end else if (r <= 7) a = 32'h0003_0000;
        else if (r == 8)     a = 32'h0003_0004;
        else                 a = 32'h0003_0008;
        return a;
    endfunction

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; mem_wr = 1'b0; mem_a = IDLE_A; mem_wdata = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);

        // Reset with rdy_in low: reset still wins
        cycle(1'b1, 1'b0, 1'b0, IDLE_A, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("rst_rdata", mem_rdata, 8'h00);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_rx_ready", rx_ready, RX_EN);

        // Seed known RAM contents for later reads
        for (int i = 0; i < 16; i++) begin
            pool[i] = 17'($urandom_range(0, 32'h1FFFF));
            cycle(1'b0, 1'b1, 1'b1, {15'h0, pool[i]}, 8'($urandom), 1'b0, 1'b0, 8'h00);
        end
        cycle(1'b0, 1'b1, 1'b1, IDLE_A, 8'h3C, 1'b0, 1'b0, 8'h00);

        // RAM write then read with one-cycle latency, held while stalled
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_1234, 8'hA5, 1'b0, 1'b0, 8'h00);
        chk8("ram_write_rdata_zero", mem_rdata, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_1234, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("ram_read_a5", mem_rdata, 8'hA5);
        cycle(1'b0, 1'b0, 1'b1, IDLE_A, 8'h77, 1'b0, 1'b0, 8'h00);
        chk8("ram_read_hold", mem_rdata, 8'hA5);
        cycle(1'b0, 1'b1, 1'b0, 32'h00FE_1234, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("ram_alias_read", mem_rdata, 8'hA5);

        // Fill the TX queue: near-full after 7, 8th accepted, 9th dropped
        cycle(1'b1, 1'b1, 1'b0, IDLE_A, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
            if (i == 6) chk1("txq_near_full_6", io_buffer_full, 1'b0);
            if (i == 7) chk1("txq_near_full_7", io_buffer_full, 1'b1);
            if (i == 8) chk1("txq_ovf_8", tx_overflow, 1'b0);
            if (i == 9) chk1("txq_ovf_9", tx_overflow, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("status_full", mem_rdata, 8'h01);
        // Push into a full queue with a simultaneous pop is accepted
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h99, 1'b1, 1'b0, 8'h00);
        chk8("full_push_pop_head", tx_data, 8'h42);
        for (int i = 0; i < 9; i++) idle(1'b1);
        chk1("txq_drained", tx_valid, 1'b0);

        // Ordered drain and push-during-pop
        cycle(1'b1, 1'b1, 1'b0, IDLE_A, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h11, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h22, 1'b0, 1'b0, 8'h00);
        chk8("txq_head_11", tx_data, 8'h11);
        idle(1'b1);
        chk8("txq_head_22", tx_data, 8'h22);
        idle(1'b1);
        chk1("txq_empty", tx_valid, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h33, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h44, 1'b1, 1'b0, 8'h00);
        chk8("push_pop_head", tx_data, 8'h44);
        idle(1'b1);

        // RX capture and read-to-clear, plus capture coinciding with a read
        idle(1'b0);
        cycle(1'b0, 1'b1, 1'b0, IDLE_A, 8'h00, 1'b0, 1'b1, 8'h5A);
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("rx_read_5a", mem_rdata, RX_EN ? 8'h5A : 8'h00);
        chk1("rx_ready_after", rx_ready, RX_EN);
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("rx_read_empty", mem_rdata, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h77);
        chk8("rx_cap_read_old", mem_rdata, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("status_rx", mem_rdata, RX_EN ? 8'h02 : 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("rx_cap_read_new", mem_rdata, RX_EN ? 8'h77 : 8'h00);

        // Halt flag is sticky across stalls, cleared only by reset
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0004, 8'h01, 1'b0, 1'b0, 8'h00);
        chk1("finish_set", program_finish, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'(i % 2), 1'b0, IDLE_A, 8'h00, 1'b0, 1'b0, 8'h00);
        chk1("finish_held", program_finish, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, IDLE_A, 8'h00, 1'b0, 1'b0, 8'h00);
        chk1("finish_cleared", program_finish, 1'b0);

        // Reset during an in-flight read of 0xFF; RAM survives
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_2468, 8'hFF, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, 8'h5C, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h6D);
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_2468, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("rst_inflight_rdata", mem_rdata, 8'h00);
        chk1("rst_flags_finish", program_finish, 1'b0);
        chk1("rst_flags_valid", tx_valid, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_2468, 8'h00, 1'b0, 1'b0, 8'h00);
        chk8("ram_survives_rst", mem_rdata, 8'hFF);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 4), rand_addr(), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 9) < 3), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
